// File: rtl/addsub_arb_pkg.sv
// addsub_arb_pkg: shared FSM states, opcodes and requester ids for the add/sub arbiter
package addsub_arb_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;
    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;
endpackage

// File: rtl/addsub_arbiter_core.sv
// addsub_core: combinational WIDTH-bit add/sub; ADDSUB_ARB_OVF_EN adds a signed overflow output
module addsub_core
    import addsub_arb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] result,
    output logic             carry_sign
`ifdef ADDSUB_ARB_OVF_EN
    ,
    output logic             ovf
`endif
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    assign b_eff      = (op == OP_SUB) ? ~b : b;
    assign sum        = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op == OP_SUB};
    assign result     = sum[WIDTH-1:0];
    // subtract reports borrow, which is the inverted carry of a + ~b + 1
    assign carry_sign = (op == OP_SUB) ? ~sum[WIDTH] : sum[WIDTH];
`ifdef ADDSUB_ARB_OVF_EN
    assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
`endif
endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin share of one add/sub core between two requesters, one op in flight.
// ADDSUB_ARB_OVF_EN adds the registered signed-overflow output rsp_ovf.
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry_sign
`ifdef ADDSUB_ARB_OVF_EN
    ,
    output logic             rsp_ovf
`endif
);
    state_t           state, state_nxt;
    logic             ptr, gnt0, gnt1;
    logic [WIDTH-1:0] a_q, b_q, core_res;
    logic             op_q, id_q, core_cs;
`ifdef ADDSUB_ARB_OVF_EN
    logic             core_ovf;
`endif

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a          (a_q),
        .b          (b_q),
        .op         (op_q),
        .result     (core_res),
        .carry_sign (core_cs)
`ifdef ADDSUB_ARB_OVF_EN
        ,
        .ovf        (core_ovf)
`endif
    );

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            IDLE: begin
                gnt0 = rst_n & req0_valid & (~req1_valid | (ptr == ID_REQ0));
                gnt1 = rst_n & req1_valid & (~req0_valid | (ptr == ID_REQ1));
                if (gnt0 | gnt1) state_nxt = EXEC;
            end
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp_valid  = (state == RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= PRIO_INIT;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= OP_ADD;
            id_q           <= ID_REQ0;
            rsp_id         <= ID_REQ0;
            rsp_result     <= '0;
            rsp_carry_sign <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
            rsp_ovf        <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (gnt0 | gnt1) begin
                a_q  <= gnt1 ? req1_a : req0_a;
                b_q  <= gnt1 ? req1_b : req0_b;
                op_q <= gnt1 ? req1_op : req0_op;
                id_q <= gnt1 ? ID_REQ1 : ID_REQ0;
            end
            if (state == EXEC) begin
                rsp_result     <= core_res;
                rsp_carry_sign <= core_cs;
                rsp_id         <= id_q;
`ifdef ADDSUB_ARB_OVF_EN
                rsp_ovf        <= core_ovf;
`endif
            end
            // the requester just served loses priority to the other one
            if (state == RESP && rsp_ready) ptr <= ~rsp_id;
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: scoreboard bench for addsub_arbiter with directed hand-computed vectors
module tb_addsub_arbiter;
    typedef struct packed {
        logic        id;
        logic [15:0] res;
        logic        cs;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_op = 1'b0;
    logic        req1_valid = 1'b0, req1_op = 1'b0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_carry_sign;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_result;
`ifdef ADDSUB_ARB_OVF_EN
    logic        rsp_ovf;
`endif

    exp_t q[$];
    logic gnt_q[$];
    int   checks = 0, passed = 0, cyc = 0, acc_cyc = 0;
    logic prev_v = 1'b0, prev_r = 1'b0;
    logic [17:0] prev_pack = '0;

    addsub_arbiter #(.WIDTH(16), .PRIO_INIT(1'b0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_a         (req0_a),
        .req0_b         (req0_b),
        .req0_op        (req0_op),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_a         (req1_a),
        .req1_b         (req1_b),
        .req1_op        (req1_op),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_result     (rsp_result),
        .rsp_carry_sign (rsp_carry_sign)
`ifdef ADDSUB_ARB_OVF_EN
        ,
        .rsp_ovf        (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic do_op(input bit p, input logic [15:0] a, input logic [15:0] b, input bit op,
                         input logic [15:0] res, input bit cs, input bit ovf);
        bit got = 1'b0;
        if (p) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
        else   begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (p ? req1_ready : req0_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            checks++;
            $display("FAIL accept_timeout port %0d: ready stayed 0, expected 1", p);
        end else q.push_back('{id: p, res: res, cs: cs, ovf: ovf});
        @(posedge clk); #1;
        if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // grant monitor
    always @(negedge clk) begin
        if (req0_ready | req1_ready) begin
            chk("grant_onehot", {31'd0, req0_ready & req1_ready}, 0);
            chk("grant_while_busy", {31'd0, rsp_valid}, 0);
            chk("ready_without_valid", {30'd0, req0_ready & ~req0_valid, req1_ready & ~req1_valid}, 0);
            acc_cyc = cyc;
            if (gnt_q.size() > 0) chk("grant_order", {31'd0, req1_ready}, {31'd0, gnt_q.pop_front()});
        end
    end

    // response monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rsp_valid && !prev_v) chk("latency", cyc - acc_cyc, 2);
            if (prev_v && !prev_r && rsp_valid) begin
                chk("rsp_hold", {14'd0, rsp_id, rsp_result, rsp_carry_sign}, {14'd0, prev_pack});
                chk("ready_in_backpressure", {30'd0, req0_ready, req1_ready}, 0);
            end
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_rsp: got id %0d result %h, expected no response", rsp_id, rsp_result);
                end else begin
                    e = q.pop_front();
                    chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                    chk("rsp_result", {16'd0, rsp_result}, {16'd0, e.res});
                    chk("rsp_carry_sign", {31'd0, rsp_carry_sign}, {31'd0, e.cs});
`ifdef ADDSUB_ARB_OVF_EN
                    chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, e.ovf});
`endif
                end
            end
        end
        prev_v    = rst_n & rsp_valid;
        prev_r    = rsp_ready;
        prev_pack = {1'b0, rsp_id, rsp_result, rsp_carry_sign};
    end

    task automatic drain();
        for (int i = 0; i < 100 && (q.size() != 0 || rsp_valid || req0_valid || req1_valid); i++)
            @(posedge clk);
        #1;
        chk("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        // reset with both requesters asking
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_ready", {30'd0, req0_ready, req1_ready}, 0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("reset_rsp_result", {16'd0, rsp_result}, 0);
        chk("reset_rsp_misc", {30'd0, rsp_id, rsp_carry_sign}, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // contention: alternating grants starting from port 0
        gnt_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        fork
            begin
                do_op(1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
                do_op(1'b0, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b0);
            end
            begin
                do_op(1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
                do_op(1'b1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0);
            end
        join
        drain();
        chk("grant_order_consumed", gnt_q.size(), 0);

        do_op(1'b0, 16'hB3E7, 16'h6EDB, 1'b0, 16'h22C2, 1'b1, 1'b0);
        do_op(1'b1, 16'hFFFF, 16'h0C02, 1'b1, 16'hF3FD, 1'b0, 1'b0);
        do_op(1'b0, 16'h6D56, 16'hD73F, 1'b1, 16'h9617, 1'b1, 1'b1);
        drain();

        // backpressure with a second request waiting
        rsp_ready = 1'b0;
        do_op(1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        fork
            do_op(1'b1, 16'h0100, 16'h0200, 1'b1, 16'hFF00, 1'b1, 1'b0);
        join_none
        repeat (7) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();

        // reset during EXEC drops the operation
        req0_a = 16'h4000; req0_b = 16'h0FFF; req0_op = 1'b0; req0_valid = 1'b1;
        for (int i = 0; i < 20 && !req0_ready; i++) @(negedge clk);
        chk("rst_test_accept", {31'd0, req0_ready}, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_exec_ready", {30'd0, req0_ready, req1_ready}, 0);
        @(negedge clk);
        chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_mid_rsp_result", {16'd0, rsp_result}, 0);
        chk("rst_mid_ready", {30'd0, req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_dropped_no_rsp", {31'd0, rsp_valid}, 0);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end
endmodule
